// File: rtl/ds_arb_pkg.sv
// Shared types and sizing helpers for the data-stream TX arbiter family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ds_arb_pkg;

    // Arbiter FSM: IDLE picks a requester, LOCKED forwards one whole packet.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DS_DATA_WIDTH_DFLT = 256;

    localparam int DS_ADDR_WIDTH_DFLT = 4;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request after last_ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; caller decides when the pick is consumed.
module rr_pick
    import ds_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    logic [IDX_W-1:0] cand;

    // Scan last_ptr+1 .. last_ptr+NUM_REQ so last_ptr itself has lowest priority.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/ds_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one NAP DS TX path among NUM_REQ requesters.
// Latency: one bubble cycle per packet for arbitration; data path fully combinational.
// Backpressure: m_ready passes straight to s_ready of the locked requester; others see 0.
module ds_tx_arbiter
    import ds_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DS_DATA_WIDTH_DFLT,
    parameter int ADDR_WIDTH = DS_ADDR_WIDTH_DFLT
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_REQ-1:0]              s_valid,
    input  logic [NUM_REQ-1:0]              s_sop,
    input  logic [NUM_REQ-1:0]              s_eop,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_data,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_addr,
    output logic [NUM_REQ-1:0]              s_ready,
    output logic                            m_valid,
    output logic                            m_sop,
    output logic                            m_eop,
    output logic [DATA_WIDTH-1:0]           m_data,
    output logic [ADDR_WIDTH-1:0]           m_addr,
    input  logic                            m_ready,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy,
    output logic                            proto_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] grant_q, grant_nxt;
    logic [IDX_W-1:0] last_ptr, last_nxt;
    logic             first_q, first_nxt;
    logic             err_q, err_nxt;

    logic [NUM_REQ-1:0] sop_req;
    logic [NUM_REQ-1:0] stray;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               xfer;

    // Only SOP beats compete; a valid beat without SOP while idle is orphaned.
    assign sop_req = s_valid & s_sop;
    assign stray   = s_valid & ~s_sop;
    assign xfer    = m_valid & m_ready;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req      (sop_req),
        .last_ptr (last_ptr),
        .found    (pick_found),
        .index    (pick_idx)
    );

    // State register; reset points last_ptr at the top so requester 0 wins first.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            grant_q  <= '0;
            last_ptr <= IDX_W'(NUM_REQ - 1);
            first_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            grant_q  <= grant_nxt;
            last_ptr <= last_nxt;
            first_q  <= first_nxt;
            err_q    <= err_nxt;
        end
    end

    // Next state: grant on a picked SOP, release on the EOP transfer, flag protocol errors.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        last_nxt  = last_ptr;
        first_nxt = first_q;
        err_nxt   = err_q;
        case (state)
            IDLE: begin
                if (|stray) begin
                    err_nxt = 1'b1;
                end
                if (pick_found) begin
                    state_nxt = LOCKED;
                    grant_nxt = pick_idx;
                    first_nxt = 1'b1;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    first_nxt = 1'b0;
                    // A fresh SOP inside an owned packet is forwarded but recorded.
                    if (m_sop && !first_q) begin
                        err_nxt = 1'b1;
                    end
                    if (m_eop) begin
                        state_nxt = IDLE;
                        last_nxt  = grant_q;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: mux the locked requester through; in idle only stray beats get a discard ready.
    always_comb begin
        s_ready = '0;
        m_valid = 1'b0;
        m_sop   = 1'b0;
        m_eop   = 1'b0;
        m_data  = '0;
        m_addr  = '0;
        if (state == LOCKED) begin
            m_valid          = s_valid[grant_q];
            m_sop            = s_sop[grant_q];
            m_eop            = s_eop[grant_q];
            m_data           = s_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
            m_addr           = s_addr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
            s_ready[grant_q] = m_ready;
        end else begin
            // Gate with resetn so nothing is acknowledged while reset is held.
            s_ready = stray & {NUM_REQ{resetn}};
        end
    end

    assign grant_id  = grant_q;
    assign busy      = (state == LOCKED);
    assign proto_err = err_q;

endmodule

// File: tb/tb_ds_tx_arbiter.sv
// Directed bench for ds_tx_arbiter: reset, RR order, backpressure, no-interleave, errors, reset mid-packet.
// Latency: checks sampled 2 time units after each rising edge.
// Backpressure: m_ready driven from a fixed toggle pattern in the stall step.
module tb_ds_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int AW = 4;

    logic               clk;
    logic               resetn;
    logic [NR-1:0]      s_valid, s_sop, s_eop, s_ready;
    logic [NR*DW-1:0]   s_data;
    logic [NR*AW-1:0]   s_addr;
    logic               m_valid, m_sop, m_eop, m_ready;
    logic [DW-1:0]      m_data;
    logic [AW-1:0]      m_addr;
    logic [1:0]         grant_id;
    logic               busy, proto_err;

    int checks   = 0;
    int failures = 0;

    ds_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .resetn(resetn),
        .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop),
        .s_data(s_data), .s_addr(s_addr), .s_ready(s_ready),
        .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop),
        .m_data(m_data), .m_addr(m_addr), .m_ready(m_ready),
        .grant_id(grant_id), .busy(busy), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic sop, input logic eop,
                           input logic [DW-1:0] d, input logic [AW-1:0] a);
        s_valid[i] = v;
        s_sop[i]   = sop;
        s_eop[i]   = eop;
        s_data[i*DW +: DW] = d;
        s_addr[i*AW +: AW] = a;
    endtask

    task automatic clr_req(input int i);
        set_req(i, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Advance to just after the next rising edge; inputs are changed here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
    endtask

    initial begin
        logic [6:0] pat;
        int beat;
        int xfers;

        resetn  = 1'b0;
        m_ready = 1'b0;
        s_valid = '0; s_sop = '0; s_eop = '0; s_data = '0; s_addr = '0;

        // ---------------- reset state ----------------
        tick();
        set_req(3, 1'b1, 1'b0, 1'b0, 8'h55, 4'h1);
        m_ready = 1'b1;
        settle();
        chk("rst_m_valid",   32'(m_valid),   32'h0);
        chk("rst_s_ready",   32'(s_ready),   32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_proto_err", 32'(proto_err), 32'h0);
        chk("rst_grant_id",  32'(grant_id),  32'h0);
        chk("rst_m_data",    32'(m_data),    32'h0);
        clr_req(3);
        tick();
        resetn = 1'b1;

        // ---------------- single requester, 3 beats ----------------
        tick();
        set_req(0, 1'b1, 1'b1, 1'b0, 8'h11, 4'h2);
        settle();
        chk("t1_idle_m_valid", 32'(m_valid), 32'h0);
        chk("t1_idle_s_ready", 32'(s_ready), 32'h0);
        tick();
        settle();
        chk("t1_b0_m_valid", 32'(m_valid), 32'h1);
        chk("t1_b0_m_sop",   32'(m_sop),   32'h1);
        chk("t1_b0_m_data",  32'(m_data),  32'h11);
        chk("t1_b0_m_addr",  32'(m_addr),  32'h2);
        chk("t1_b0_s_ready", 32'(s_ready), 32'h1);
        chk("t1_b0_busy",    32'(busy),    32'h1);
        tick();
        set_req(0, 1'b1, 1'b0, 1'b0, 8'h22, 4'h2);
        settle();
        chk("t1_b1_m_data", 32'(m_data), 32'h22);
        chk("t1_b1_m_sop",  32'(m_sop),  32'h0);
        tick();
        set_req(0, 1'b1, 1'b0, 1'b1, 8'h33, 4'h2);
        settle();
        chk("t1_b2_m_data", 32'(m_data), 32'h33);
        chk("t1_b2_m_eop",  32'(m_eop),  32'h1);
        tick();
        clr_req(0);
        settle();
        chk("t1_end_busy",     32'(busy),     32'h0);
        chk("t1_end_m_valid",  32'(m_valid),  32'h0);
        chk("t1_end_grant_id", 32'(grant_id), 32'h0);

        // ---------------- four simultaneous 1-beat packets, two rounds ----------------
        pulse_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, 1'b1, 8'(8'hA0 + 16*r + i), 4'(i));
            for (int p = 0; p < NR; p++) begin
                settle();
                chk("t2_bubble_m_valid", 32'(m_valid), 32'h0);
                chk("t2_bubble_busy",    32'(busy),    32'h0);
                tick();
                settle();
                chk("t2_grant_id", 32'(grant_id), 32'(p));
                chk("t2_m_data",   32'(m_data),   32'(8'hA0 + 16*r + p));
                chk("t2_s_ready",  32'(s_ready),  32'(1 << p));
                tick();
                clr_req(p);
            end
        end

        // ---------------- backpressure, req1 4 beats ----------------
        pat     = 7'b1011001;
        m_ready = 1'b0;
        set_req(1, 1'b1, 1'b1, 1'b0, 8'hB0, 4'h5);
        tick();
        beat  = 0;
        xfers = 0;
        for (int c = 0; c < 7; c++) begin
            m_ready = pat[c];
            settle();
            chk("t3_m_valid", 32'(m_valid), 32'h1);
            chk("t3_m_data",  32'(m_data),  32'(8'hB0 + beat));
            chk("t3_s_ready", 32'(s_ready), 32'({2'b00, pat[c], 1'b0}));
            if (m_valid && m_ready) xfers++;
            tick();
            if (pat[c]) begin
                beat++;
                if (beat < 4) set_req(1, 1'b1, 1'b0, (beat == 3), 8'(8'hB0 + beat), 4'h5);
            end
        end
        clr_req(1);
        m_ready = 1'b1;
        settle();
        chk("t3_xfers", 32'(xfers), 32'd4);
        chk("t3_busy",  32'(busy),  32'h0);

        // ---------------- no interleave: req0 SOP during req2 packet ----------------
        set_req(2, 1'b1, 1'b1, 1'b0, 8'hD0, 4'h7);
        tick();
        for (int b = 0; b < 5; b++) begin
            set_req(2, 1'b1, (b == 0), (b == 4), 8'(8'hD0 + b), 4'h7);
            if (b == 1) set_req(0, 1'b1, 1'b1, 1'b1, 8'hC0, 4'h3);
            settle();
            chk("t4_grant_id", 32'(grant_id), 32'h2);
            chk("t4_m_data",   32'(m_data),   32'(8'hD0 + b));
            chk("t4_s_ready",  32'(s_ready),  32'h4);
            tick();
        end
        clr_req(2);
        settle();
        chk("t4_bubble_busy",    32'(busy),    32'h0);
        chk("t4_bubble_s_ready", 32'(s_ready), 32'h0);
        tick();
        settle();
        chk("t4_req0_grant", 32'(grant_id), 32'h0);
        chk("t4_req0_data",  32'(m_data),   32'hC0);
        tick();
        clr_req(0);

        // ---------------- stray beat while idle ----------------
        set_req(3, 1'b1, 1'b0, 1'b0, 8'hEE, 4'h9);
        settle();
        chk("t5_s_ready",    32'(s_ready),   32'h8);
        chk("t5_m_valid",    32'(m_valid),   32'h0);
        chk("t5_err_before", 32'(proto_err), 32'h0);
        tick();
        clr_req(3);
        settle();
        chk("t5_err_set",  32'(proto_err), 32'h1);
        chk("t5_busy",     32'(busy),      32'h0);
        tick();
        tick();
        settle();
        chk("t5_err_sticky", 32'(proto_err), 32'h1);
        pulse_reset();
        settle();
        chk("t5_err_cleared", 32'(proto_err), 32'h0);

        // ---------------- second SOP inside a packet ----------------
        tick();
        set_req(1, 1'b1, 1'b1, 1'b0, 8'h61, 4'h1);
        tick();
        settle();
        chk("t6_grant_id", 32'(grant_id), 32'h1);
        tick();
        set_req(1, 1'b1, 1'b1, 1'b1, 8'h62, 4'h1);
        settle();
        chk("t6_b1_fwd",   32'({m_valid, m_sop, m_data}), 32'({2'b11, 8'h62}));
        chk("t6_err_pre",  32'(proto_err), 32'h0);
        tick();
        clr_req(1);
        settle();
        chk("t6_err_post", 32'(proto_err), 32'h1);
        chk("t6_busy",     32'(busy),      32'h0);

        // ---------------- reset mid-packet ----------------
        set_req(2, 1'b1, 1'b1, 1'b0, 8'h70, 4'h4);
        tick();
        tick();
        set_req(2, 1'b1, 1'b0, 1'b0, 8'h71, 4'h4);
        settle();
        chk("t7_pre_busy", 32'(busy), 32'h1);
        resetn = 1'b0;
        #1;
        chk("t7_rst_m_valid",   32'(m_valid),   32'h0);
        chk("t7_rst_s_ready",   32'(s_ready),   32'h0);
        chk("t7_rst_busy",      32'(busy),      32'h0);
        chk("t7_rst_proto_err", 32'(proto_err), 32'h0);
        set_req(2, 1'b1, 1'b1, 1'b1, 8'h72, 4'h4);
        set_req(0, 1'b1, 1'b1, 1'b1, 8'h80, 4'h6);
        resetn = 1'b1;
        settle();
        chk("t7_rel_m_valid", 32'(m_valid), 32'h0);
        tick();
        settle();
        chk("t7_first_grant", 32'(grant_id), 32'h0);
        chk("t7_first_data",  32'(m_data),   32'h80);
        tick();
        clr_req(0);
        clr_req(2);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
